// File: rtl/random_word_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_word_buffer: packs entropy bytes into words, runs a               |
// | repetition-count health test and buffers words in a small FIFO.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module random_word_buffer #(
  parameter int RATE         = 8,
  parameter int WORDSIZE     = 32,
  parameter int DEPTH        = 4,
  parameter int REPEAT_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RATE-1:0]              in,
  input  logic                         in_valid,
  output logic                         in_received,
  output logic [WORDSIZE-1:0]          out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         health_fail
);

  localparam int SLOTS  = WORDSIZE / RATE;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int REP_W  = $clog2(REPEAT_LIMIT + 1);

  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_LIMIT);

  logic                 rcv_q,    rcv_d;
  logic                 health_q, health_d;
  logic                 have_q,   have_d;
  logic [RATE-1:0]      prev_q,   prev_d;
  logic [REP_W-1:0]     rep_q,    rep_d;
  logic [SLOT_W-1:0]    slot_q,   slot_d;
  logic [WORDSIZE-1:0]  word_q,   word_d;
  logic [PTR_W-1:0]     wr_q,     wr_d;
  logic [PTR_W-1:0]     rd_q,     rd_d;
  logic [LVL_W-1:0]     level_q,  level_d;
  logic [WORDSIZE-1:0]  mem_q [DEPTH];

  logic                 w_capture;
  logic                 w_trip;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [REP_W-1:0]     w_rep_next;
  logic [WORDSIZE-1:0]  w_word;

  always_comb begin
    w_capture  = in_valid && !rcv_q && (health_q || (level_q != DEPTH_L));
    if (have_q && (in == prev_q))
      w_rep_next = (rep_q == REP_MAX) ? REP_MAX : rep_q + REP_W'(1);
    else
      w_rep_next = REP_W'(1);
    w_trip     = w_capture && !health_q && (w_rep_next == REP_MAX);
    w_accept   = w_capture && !health_q && !w_trip;
    w_push     = w_accept && (slot_q == SLOT_LAST);
    w_pop      = out_valid && out_ready;
    w_word     = word_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot_q == SLOT_W'(k))
        w_word[k*RATE +: RATE] = in;
    end
  end

  always_comb begin
    rcv_d    = w_capture;
    health_d = health_q | w_trip;
    have_d   = have_q;
    prev_d   = prev_q;
    rep_d    = rep_q;
    slot_d   = slot_q;
    word_d   = word_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    level_d  = level_q;
    if (w_capture) begin
      have_d = 1'b1;
      prev_d = in;
      rep_d  = w_rep_next;
    end
    if (w_trip) begin
      // Failure discards the partial word and everything already buffered.
      slot_d  = '0;
      word_d  = '0;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (w_accept) begin
        slot_d = w_push ? '0 : slot_q + SLOT_W'(1);
        word_d = w_push ? '0 : w_word;
      end
      if (w_push) wr_d = wr_q + PTR_W'(1);
      if (w_pop)  rd_d = rd_q + PTR_W'(1);
      if (w_push && !w_pop)      level_d = level_q + LVL_W'(1);
      else if (!w_push && w_pop) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rcv_q    <= 1'b0;
      health_q <= 1'b0;
      have_q   <= 1'b0;
      prev_q   <= '0;
      rep_q    <= '0;
      slot_q   <= '0;
      word_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
    end else begin
      rcv_q    <= rcv_d;
      health_q <= health_d;
      have_q   <= have_d;
      prev_q   <= prev_d;
      rep_q    <= rep_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push)
      mem_q[wr_q] <= w_word;
  end

  assign in_received = rcv_q;
  assign level       = level_q;
  assign health_fail = health_q;
  assign out_valid   = (level_q != '0) && !health_q;
  assign out         = (level_q != '0) ? mem_q[rd_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_random_word_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_random_word_buffer: directed scenarios plus random traffic, compared  |
// | against a queue-based reference model every cycle.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_random_word_buffer;
  localparam int RATE  = 8;
  localparam int WSIZE = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 4;
  localparam int SLOTS = WSIZE / RATE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [RATE-1:0]  din = '0;
  logic             din_v = 1'b0;
  logic             ordy = 1'b0;
  logic             rcv;
  logic [WSIZE-1:0] dout;
  logic             dout_v;
  logic [2:0]       lvl;
  logic             hfail;

  random_word_buffer #(.RATE(RATE), .WORDSIZE(WSIZE), .DEPTH(DEPTH), .REPEAT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_v), .in_received(rcv),
    .out(dout), .out_valid(dout_v), .out_ready(ordy), .level(lvl), .health_fail(hfail)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [WSIZE-1:0] m_q[$];
  logic [RATE-1:0]  m_part[$];
  logic [RATE-1:0]  m_prev;
  bit               m_have, m_rcv, m_fail;
  int               m_rep;

  task automatic model_edge();
    bit cap, pop;
    logic [WSIZE-1:0] w;
    if (!rst) begin
      m_q.delete(); m_part.delete();
      m_have = 0; m_rcv = 0; m_fail = 0; m_rep = 0; m_prev = '0;
      return;
    end
    pop = (m_q.size() != 0) && !m_fail && ordy;
    cap = din_v && !m_rcv && (m_fail || m_q.size() < DEPTH);
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      m_rep  = (m_have && din == m_prev) ? ((m_rep + 1 > LIM) ? LIM : m_rep + 1) : 1;
      m_prev = din;
      m_have = 1;
      if (!m_fail) begin
        if (m_rep == LIM) begin
          m_fail = 1; m_q.delete(); m_part.delete();
        end else begin
          m_part.push_back(din);
          if (m_part.size() == SLOTS) begin
            w = '0;
            for (int k = 0; k < SLOTS; k++) w[k*RATE +: RATE] = m_part[k];
            m_q.push_back(w);
            m_part.delete();
          end
        end
      end
    end
    m_rcv = cap;
  endtask

  task automatic compare_all();
    check_eq("in_received", rcv, m_rcv);
    check_eq("level", lvl, m_q.size());
    check_eq("health_fail", hfail, m_fail);
    check_eq("out_valid", dout_v, (m_q.size() != 0) && !m_fail);
    check_eq("out", dout, (m_q.size() != 0) ? m_q[0] : '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Present a byte and hold it until the block acknowledges it.
  task automatic feed(input logic [RATE-1:0] b);
    din = b; din_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rcv) return;
    end
    check_eq("feed_timeout", rcv, 1);
  endtask

  task automatic do_reset();
    din_v = 1'b0; ordy = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_level", lvl, 0);
    check_eq("rst_out", dout, 0);
    check_eq("rst_rcv", rcv, 0);

    // Basic packing
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    check_eq("basic_out", dout, 32'h44332211);
    check_eq("basic_valid", dout_v, 1);
    check_eq("basic_level", lvl, 1);

    // Full stall, one pop, then the held byte goes through
    do_reset();
    for (int i = 0; i < 16; i++) feed(RATE'(8'h20 + i));
    check_eq("full_level", lvl, 4);
    din = 8'h55; din_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("stall_rcv", rcv, 0);
    end
    ordy = 1'b1; step(); ordy = 1'b0;
    check_eq("pop_level", lvl, 3);
    check_eq("pop_rcv", rcv, 0);
    step();
    check_eq("resume_rcv", rcv, 1);

    // Push and pop on the same edge
    do_reset();
    for (int i = 1; i <= 11; i++) feed(RATE'(i));
    din = 8'h0c;
    step();
    ordy = 1'b1; step(); ordy = 1'b0;
    check_eq("pp_rcv", rcv, 1);
    check_eq("pp_level", lvl, 2);
    check_eq("pp_head", dout, 32'h08070605);
    din_v = 1'b0; ordy = 1'b1; step(); ordy = 1'b0;
    check_eq("pp_next", dout, 32'h0c0b0a09);

    // Health trip: AA x3 then AB does not trip, AA x4 does
    do_reset();
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    feed(8'hAA); feed(8'hAA); feed(8'hAA); feed(8'hAB);
    check_eq("no_trip", hfail, 0);
    check_eq("no_trip_level", lvl, 2);
    feed(8'hAA); feed(8'hAA); feed(8'hAA); feed(8'hAA);
    check_eq("trip", hfail, 1);
    check_eq("trip_level", lvl, 0);
    check_eq("trip_valid", dout_v, 0);
    feed(8'h10); feed(8'h11); feed(8'h12);
    check_eq("trip_sticky", hfail, 1);

    // Reset mid-word
    do_reset();
    feed(8'h71); feed(8'h72);
    din_v = 1'b0; rst = 1'b0; step(); rst = 1'b1;
    check_eq("mid_rcv", rcv, 0);
    check_eq("mid_level", lvl, 0);
    check_eq("mid_hfail", hfail, 0);
    feed(8'hD1); feed(8'hD2); feed(8'hD3); feed(8'hD4);
    check_eq("mid_word", dout, 32'hD4D3D2D1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!din_v || rcv) begin
        din_v = ($urandom_range(0, 9) < 7);
        din = ($urandom_range(0, 3) == 0) ? RATE'($urandom_range(0, 2)) : RATE'($urandom);
      end
      ordy = $urandom_range(0, 1);
      rst  = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
